// File: rtl/branch_predict_unit.sv
// Direct-mapped branch target predictor with per-entry saturating counters.
// After reset or a flush, the table is swept one entry per cycle before
// lookups and updates are accepted.
//
// state   | meaning
// --------+-----------------------------------------------------------
// ST_INIT | sweep pointer clears one valid bit per cycle; ready = 0
// ST_RUN  | table accepts lookups and updates; ready = 1
module branch_predict_unit #(
  parameter int ENTRIES = 16,
  parameter int CNT_W   = 2,
  parameter int STAT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush_table,
  output logic              ready,
  input  logic              lookup_valid,
  input  logic [31:0]       lookup_pc,
  output logic              pred_valid,
  output logic              pred_hit,
  output logic              pred_taken,
  output logic [31:0]       pred_target,
  input  logic              update_valid,
  input  logic [31:0]       update_pc,
  input  logic              update_taken,
  input  logic [31:0]       update_target,
  input  logic              update_mispredict,
  output logic [STAT_W-1:0] stat_lookups,
  output logic [STAT_W-1:0] stat_mispredicts
);

  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TAG_W = 30 - IDX_W;

  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(ENTRIES - 1);
  localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0]  CNT_MAX  = CNT_W'((1 << CNT_W) - 1);
  localparam logic [CNT_W-1:0]  CNT_WEAK = CNT_W'(1 << (CNT_W - 1));
  localparam logic [STAT_W-1:0] STAT_ONE = STAT_W'(1);
  localparam logic [STAT_W-1:0] STAT_MAX = '1;

  typedef enum logic {ST_INIT, ST_RUN} state_t;

  state_t           state;
  logic [IDX_W-1:0] sweep_ptr;

  logic             tbl_valid  [ENTRIES];
  logic [TAG_W-1:0] tbl_tag    [ENTRIES];
  logic [31:0]      tbl_target [ENTRIES];
  logic [CNT_W-1:0] tbl_cnt    [ENTRIES];

  logic [IDX_W-1:0] lk_idx, up_idx;
  logic [TAG_W-1:0] lk_tag, up_tag;
  logic             lk_acc, up_acc, lk_hit, lk_taken, up_hit;
  logic [CNT_W-1:0] up_cnt;
  logic [1:0]       unused_upd_lsb;

  assign lk_idx   = lookup_pc[IDX_W+1:2];
  assign lk_tag   = lookup_pc[31:IDX_W+2];
  assign up_idx   = update_pc[IDX_W+1:2];
  assign up_tag   = update_pc[31:IDX_W+2];
  assign unused_upd_lsb = update_pc[1:0];

  // a flush in the same cycle drops the update entirely
  assign lk_acc   = lookup_valid && ready;
  assign up_acc   = update_valid && ready && !flush_table;

  assign lk_hit   = tbl_valid[lk_idx] && (tbl_tag[lk_idx] == lk_tag);
  assign lk_taken = lk_hit && tbl_cnt[lk_idx][CNT_W-1];
  assign up_hit   = tbl_valid[up_idx] && (tbl_tag[up_idx] == up_tag);
  assign up_cnt   = tbl_cnt[up_idx];

  // sequencing: sweep the table in INIT, then sit in RUN until flushed
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_INIT;
      sweep_ptr <= '0;
      ready     <= 1'b0;
    end else if (flush_table) begin
      state     <= ST_INIT;
      sweep_ptr <= '0;
      ready     <= 1'b0;
    end else begin
      case (state)
        ST_INIT: begin
          sweep_ptr <= sweep_ptr + IDX_W'(1);
          if (sweep_ptr == LAST_IDX) begin
            state <= ST_RUN;
            ready <= 1'b1;
          end
        end
        ST_RUN: begin
          state <= ST_RUN;
        end
        default: begin
          state     <= ST_INIT;
          sweep_ptr <= '0;
          ready     <= 1'b0;
        end
      endcase
    end
  end

  // table storage: sweep clears, resolved branches train or allocate
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state == ST_INIT) begin
        tbl_valid[sweep_ptr] <= 1'b0;
      end else if (up_acc) begin
        if (up_hit) begin
          if (update_taken) begin
            tbl_cnt[up_idx]    <= (up_cnt == CNT_MAX) ? up_cnt : up_cnt + CNT_ONE;
            tbl_target[up_idx] <= update_target;
          end else begin
            tbl_cnt[up_idx]    <= (up_cnt == '0) ? up_cnt : up_cnt - CNT_ONE;
          end
        end else if (update_taken) begin
          tbl_valid[up_idx]  <= 1'b1;
          tbl_tag[up_idx]    <= up_tag;
          tbl_target[up_idx] <= update_target;
          tbl_cnt[up_idx]    <= CNT_WEAK;
        end
      end
    end
  end

  // registered prediction; reads see pre-update contents of this cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      pred_valid  <= 1'b0;
      pred_hit    <= 1'b0;
      pred_taken  <= 1'b0;
      pred_target <= '0;
    end else begin
      pred_valid <= lk_acc;
      if (lk_acc) begin
        pred_hit    <= lk_hit;
        pred_taken  <= lk_taken;
        pred_target <= lk_taken ? tbl_target[lk_idx] : lookup_pc + 32'd4;
      end
    end
  end

  // saturating statistics, kept across flushes
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_lookups     <= '0;
      stat_mispredicts <= '0;
    end else begin
      if (lk_acc && stat_lookups != STAT_MAX)
        stat_lookups <= stat_lookups + STAT_ONE;
      if (up_acc && update_mispredict && stat_mispredicts != STAT_MAX)
        stat_mispredicts <= stat_mispredicts + STAT_ONE;
    end
  end

endmodule

// File: tb/tb_branch_predict_unit.sv
// Scoreboard bench for branch_predict_unit: stimulus pushes expected
// predictions from an array-based reference model; a negedge monitor pops
// and compares whenever pred_valid is seen.
module tb_branch_predict_unit;

  logic        clk = 1'b0;
  logic        rst, flush_table, ready;
  logic        lookup_valid;
  logic [31:0] lookup_pc;
  logic        pred_valid, pred_hit, pred_taken;
  logic [31:0] pred_target;
  logic        update_valid;
  logic [31:0] update_pc;
  logic        update_taken;
  logic [31:0] update_target;
  logic        update_mispredict;
  logic [15:0] stat_lookups, stat_mispredicts;

  branch_predict_unit #(.ENTRIES(16), .CNT_W(2), .STAT_W(16)) dut (
    .clk(clk), .rst(rst), .flush_table(flush_table), .ready(ready),
    .lookup_valid(lookup_valid), .lookup_pc(lookup_pc),
    .pred_valid(pred_valid), .pred_hit(pred_hit), .pred_taken(pred_taken),
    .pred_target(pred_target),
    .update_valid(update_valid), .update_pc(update_pc), .update_taken(update_taken),
    .update_target(update_target), .update_mispredict(update_mispredict),
    .stat_lookups(stat_lookups), .stat_mispredicts(stat_mispredicts)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  always @(posedge clk) cyc++;

  typedef struct {
    bit        hit;
    bit        taken;
    bit [31:0] tgt;
    int        stamp;
  } exp_t;
  exp_t sb[$];
  exp_t mon_e;

  // reference model: plain arrays, index = (pc/4) mod 16, tag = pc/64
  bit        m_valid [16];
  bit [31:0] m_tag   [16];
  bit [31:0] m_tgt   [16];
  int        m_cnt   [16];
  bit        m_ready;
  int        m_init_left;
  int        m_lookups;
  int        m_misp;

  task automatic check(string name, bit [31:0] act, bit [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int idx_of(bit [31:0] pc);
    return int'((pc / 4) % 16);
  endfunction

  function automatic bit [31:0] tag_of(bit [31:0] pc);
    return pc / 64;
  endfunction

  function automatic bit [31:0] rand_pc();
    if ($urandom_range(0, 15) == 0) return 32'hFFFF_FFFC;
    return 32'h0040_0000 + ($urandom_range(0, 2) << 6) + ($urandom_range(0, 15) << 2);
  endfunction

  // monitor: pops one expectation per pred_valid and checks its latency
  always @(negedge clk) begin
    if (pred_valid) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL pred_spurious: got pred_valid=1 expected 0 (cycle %0d)", cyc);
      end else begin
        mon_e = sb.pop_front();
        check("pred_latency", cyc, mon_e.stamp + 1);
        check("pred_hit", 32'(pred_hit), 32'(mon_e.hit));
        check("pred_taken", 32'(pred_taken), 32'(mon_e.taken));
        check("pred_target", pred_target, mon_e.tgt);
      end
    end else if (sb.size() != 0 && cyc > sb[0].stamp) begin
      checks++;
      errors++;
      $display("FAIL pred_missing: got pred_valid=0 expected 1 (cycle %0d)", cyc);
      void'(sb.pop_front());
    end
  end

  task automatic idle_inputs();
    flush_table = 0; lookup_valid = 0; lookup_pc = 0;
    update_valid = 0; update_pc = 0; update_taken = 0;
    update_target = 0; update_mispredict = 0;
  endtask

  task automatic model_clear();
    for (int k = 0; k < 16; k++) m_valid[k] = 0;
  endtask

  task automatic do_cycle(bit lv, bit [31:0] lpc, bit uv, bit [31:0] upc,
                          bit ut, bit [31:0] utgt, bit um, bit fl);
    exp_t e;
    int   i;
    bit   hit;
    lookup_valid = lv; lookup_pc = lpc;
    update_valid = uv; update_pc = upc; update_taken = ut;
    update_target = utgt; update_mispredict = um; flush_table = fl;
    if (lv && m_ready) begin
      i       = idx_of(lpc);
      e.hit   = m_valid[i] && m_tag[i] == tag_of(lpc);
      e.taken = e.hit && m_cnt[i] >= 2;
      e.tgt   = e.taken ? m_tgt[i] : lpc + 32'd4;
      e.stamp = cyc;
      sb.push_back(e);
      if (m_lookups < 65535) m_lookups++;
    end
    if (uv && m_ready && !fl) begin
      i   = idx_of(upc);
      hit = m_valid[i] && m_tag[i] == tag_of(upc);
      if (hit) begin
        if (ut) begin
          m_cnt[i] = (m_cnt[i] < 3) ? m_cnt[i] + 1 : 3;
          m_tgt[i] = utgt;
        end else begin
          m_cnt[i] = (m_cnt[i] > 0) ? m_cnt[i] - 1 : 0;
        end
      end else if (ut) begin
        m_valid[i] = 1; m_tag[i] = tag_of(upc); m_tgt[i] = utgt; m_cnt[i] = 2;
      end
      if (um && m_misp < 65535) m_misp++;
    end
    if (fl) begin
      m_ready = 0; m_init_left = 16; model_clear();
    end else if (!m_ready) begin
      m_init_left--;
      if (m_init_left == 0) m_ready = 1;
    end
    @(posedge clk); #1;
    idle_inputs();
    check("ready", 32'(ready), 32'(m_ready));
    check("stat_lookups", 32'(stat_lookups), 32'(m_lookups));
    check("stat_mispredicts", 32'(stat_mispredicts), 32'(m_misp));
  endtask

  task automatic lookup(bit [31:0] pc);
    do_cycle(1, pc, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic update(bit [31:0] pc, bit taken, bit [31:0] tgt);
    do_cycle(0, 0, 1, pc, taken, tgt, 0, 0);
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ready", 32'(ready), 0);
    check("rst_pred_valid", 32'(pred_valid), 0);
    check("rst_pred_hit", 32'(pred_hit), 0);
    check("rst_pred_taken", 32'(pred_taken), 0);
    check("rst_pred_target", pred_target, 0);
    check("rst_stat_lookups", 32'(stat_lookups), 0);
    check("rst_stat_mispredicts", 32'(stat_mispredicts), 0);
    m_ready = 0; m_init_left = 16; m_lookups = 0; m_misp = 0;
    model_clear();
    rst = 0;
  endtask

  initial begin
    rst = 1;
    idle_inputs();
    do_reset();

    // sweep after reset: lookups are refused, ready rises after 16 clocks
    for (int k = 0; k < 16; k++) do_cycle(1, 32'h0040_0010, 0, 0, 0, 0, 0, 0);

    // cold lookup, allocate, train up, train down to zero
    lookup(32'h0040_0010);
    update(32'h0040_0010, 1, 32'h0040_0100);
    lookup(32'h0040_0010);
    update(32'h0040_0010, 1, 32'h0040_0100);
    update(32'h0040_0010, 1, 32'h0040_0100);
    lookup(32'h0040_0010);
    update(32'h0040_0010, 0, 0);
    update(32'h0040_0010, 0, 0);
    lookup(32'h0040_0010);
    update(32'h0040_0010, 0, 0);
    update(32'h0040_0010, 0, 0);
    update(32'h0040_0010, 0, 0);
    update(32'h0040_0010, 1, 32'h0040_0180);
    lookup(32'h0040_0010);

    // alias on index 4 replaces the entry
    lookup(32'h0040_0050);
    update(32'h0040_0050, 1, 32'h0040_0200);
    lookup(32'h0040_0010);
    lookup(32'h0040_0050);

    // fall-through wrap at the top of the address space
    lookup(32'hFFFF_FFFC);

    // same-cycle lookup and allocating update: read before write
    do_cycle(1, 32'h0040_0020, 1, 32'h0040_0020, 1, 32'h0040_0300, 1, 0);
    lookup(32'h0040_0020);

    // flush: refused for 16 cycles, prior entries gone, stats kept
    do_cycle(0, 0, 0, 0, 0, 0, 0, 1);
    for (int k = 0; k < 16; k++) do_cycle(1, 32'h0040_0020, 1, 32'h0040_0020, 1, 32'h1, 1, 0);
    lookup(32'h0040_0020);
    lookup(32'h0040_0050);

    // randomized traffic including occasional flushes
    for (int k = 0; k < 600; k++) begin
      do_cycle(1'($urandom_range(0, 1)), rand_pc(),
               1'($urandom_range(0, 1)), rand_pc(), 1'($urandom_range(0, 1)),
               $urandom & 32'hFFFF_FFFC, 1'($urandom_range(0, 1)),
               $urandom_range(0, 79) == 0);
    end
    for (int k = 0; k < 17; k++) lookup(rand_pc());

    // mispredict counter saturation
    for (int k = 0; k < 70000; k++) do_cycle(0, 0, 1, 32'h0040_0080, 0, 0, 1, 0);
    check("stat_mispredicts_sat", 32'(stat_mispredicts), 32'h0000_FFFF);
    lookup(32'h0040_0080);

    // reset in RUN restarts the sweep and clears statistics
    do_reset();
    for (int k = 0; k < 16; k++) do_cycle(0, 0, 0, 0, 0, 0, 0, 0);
    lookup(32'h0040_0050);

    @(posedge clk); #1;
    @(posedge clk); #1;
    check("sb_drained", 32'(sb.size()), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/branch_predict_unit.md
BRANCH_PREDICT_UNIT -- requirements
Module: branch_predict_unit

Interface
REQ-001 Parameter ENTRIES, default 16, table depth; power of two, 4..256.
REQ-002 Parameter CNT_W, default 2, per-entry saturating counter width; 1..4.
REQ-003 Parameter STAT_W, default 16, width of statistics counters.
REQ-004 Derived IDX_W = log2(ENTRIES); TAG_W = 30 - IDX_W.
REQ-005 clk  input  1  single clock; all state on rising edge.
REQ-006 rst  input  1  reset, synchronous, active-high.
REQ-007 flush_table  input  1  one-cycle pulse; invalidate whole table.
REQ-008 ready  output  1  high when table accepts lookups/updates.
REQ-009 lookup_valid  input  1  lookup request this cycle.
REQ-010 lookup_pc  input  32  fetch PC (word aligned).
REQ-011 pred_valid  output  1  prediction result valid.
REQ-012 pred_hit  output  1  entry matched lookup_pc.
REQ-013 pred_taken  output  1  predicted taken.
REQ-014 pred_target  output  32  predicted next PC.
REQ-015 update_valid  input  1  resolved-branch update this cycle.
REQ-016 update_pc  input  32  PC of resolved branch.
REQ-017 update_taken  input  1  actual outcome.
REQ-018 update_target  input  32  actual taken target.
REQ-019 update_mispredict  input  1  pipeline flushed for this branch.
REQ-020 stat_lookups  output  STAT_W  accepted lookups.
REQ-021 stat_mispredicts  output  STAT_W  accepted updates with update_mispredict=1.

Function
REQ-022 Index = pc[IDX_W+1:2]; tag = pc[31:IDX_W+2]; entry = {valid, tag, target[31:0], cnt[CNT_W-1:0]}.
REQ-023 FSM states INIT, RUN; ready = 1 only in RUN.
REQ-024 INIT: sweep pointer clears valid of one entry per cycle, index 0 to ENTRIES-1; after entry ENTRIES-1 cleared, next state RUN.
REQ-025 RUN -> INIT on flush_table=1; sweep pointer restarts at 0; flush_table in INIT restarts sweep at 0.
REQ-026 Lookup accepted when lookup_valid=1 and ready=1; result registered, latency exactly 1 cycle.
REQ-027 pred_valid = 1 the cycle after an accepted lookup, else 0.
REQ-028 pred_hit = valid and tag equal; pred_taken = pred_hit and cnt[CNT_W-1].
REQ-029 pred_target = stored target if pred_taken, else lookup_pc + 4 (mod 2^32, wraps at 0xFFFFFFFC).
REQ-030 Update accepted when update_valid=1 and ready=1; ignored in INIT (no table or stat change).
REQ-031 Update hit: cnt +1 if taken, -1 if not; saturate at 2^CNT_W-1 and 0; target overwritten only when taken.
REQ-032 Update miss, taken: allocate/replace entry: valid=1, new tag, target, cnt = 2^(CNT_W-1) (weakly taken).
REQ-033 Update miss, not taken: no table change.
REQ-034 Same-cycle lookup and update to same index: lookup returns pre-update contents (read-before-write).
REQ-035 flush_table same cycle as update: flush wins, update dropped.
REQ-036 stat_lookups +1 per accepted lookup; stat_mispredicts +1 per accepted update with update_mispredict=1; both saturate at 2^STAT_W-1, not cleared by flush_table.

Reset
REQ-037 rst=1: state INIT, sweep pointer 0, ready=0, pred_valid=0, pred_hit=0, pred_taken=0, pred_target=0, both stat counters 0.
REQ-038 rst asserted mid-sweep or mid-RUN restarts sweep at index 0; table contents need not be cleared in the rst cycle itself.
REQ-039 First RUN cycle occurs exactly ENTRIES clocks after the first clock with rst=0.

Verification (ENTRIES=16, CNT_W=2, STAT_W=16)
REQ-040 Release rst -> ready=0 for 16 cycles, ready=1 on cycle 17; lookups during INIT give pred_valid=0, stat_lookups=0.
REQ-041 Cold lookup 0x00400010 -> next cycle pred_valid=1, pred_hit=0, pred_taken=0, pred_target=0x00400014.
REQ-042 Update pc 0x00400010 taken target 0x00400100, then lookup -> pred_hit=1, pred_taken=1, pred_target=0x00400100; second taken update saturates cnt at 3; then 2 not-taken updates -> cnt 1, pred_taken=0; 2 more not-taken -> cnt 0 (no underflow).
REQ-043 Alias 0x00400050 (same index 4, different tag) -> pred_hit=0; taken update to 0x00400200 replaces entry; lookup 0x00400010 then misses.
REQ-044 flush_table pulse in RUN -> ready=0 next cycle for 16 cycles; all prior entries miss; stat counters unchanged.
REQ-045 Same-cycle lookup and taken update to cold 0x00400020 -> pred_hit=0; following lookup pred_hit=1; 70000 mispredict updates -> stat_mispredicts=0xFFFF.
